led_breather: RTL



---
 rtl/led_breather.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/led_breather.sv
// ----------------------------------------------------------------------------
// led_breather
//
// Breathing LED driver: a PWM output whose duty ramps up one step per PWM
// period, holds at full scale, ramps down, holds at zero, and repeats.
// All timing derives from clk_freq_hz so the same board-frequency parameter
// used upstream in the blinky divider path also sets the breath rate.
//
// Parameters:
//   clk_freq_hz  - input clock frequency in Hz
//   pwm_freq_hz  - PWM period rate in Hz
//   duty_bits    - PWM resolution N; one PWM period is 2^N slots
//   hold_periods - PWM periods spent at the top and at the bottom (>= 1)
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset (wins over everything)
//   en          in   run enable; low freezes all counters and the FSM
//   led0        out  registered PWM LED drive
//   duty        out  current (linear) duty value, duty_bits wide
//   dir         out  1 while ramping up (RISE), 0 otherwise
//   period_tick out  one-cycle pulse in the cycle pwm_cnt returns to 0
//
// Build option:
//   GAMMA_EN - when defined, the PWM compare uses (duty*duty) >> duty_bits
//              for a perceptually linear fade; the duty port still reports
//              the linear value. When undefined the compare uses duty
//              directly and no multiplier is built.
//
// FSM states:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RISE   | duty increments once per PWM period until it reaches max
//   TOP    | duty held at max for hold_periods PWM periods
//   FALL   | duty decrements once per PWM period until it reaches 0
//   BOTTOM | duty held at 0 for hold_periods PWM periods
// ----------------------------------------------------------------------------
module led_breather #(
  parameter int clk_freq_hz  = 12_000_000,
  parameter int pwm_freq_hz  = 1000,
  parameter int duty_bits    = 8,
  parameter int hold_periods = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 led0,
  output logic [duty_bits-1:0] duty,
  output logic                 dir,
  output logic                 period_tick
);

  // Clock cycles per PWM slot; never below one so a slow clock still runs.
  localparam int PRESC_RAW = clk_freq_hz / (pwm_freq_hz * (1 << duty_bits));
  localparam int PRESC     = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
  localparam int PRESC_W   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int HOLD_W    = (hold_periods > 1) ? $clog2(hold_periods) : 1;

  localparam logic [PRESC_W-1:0]   PRESC_LAST    = PRESC_W'(PRESC - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST     = HOLD_W'(hold_periods - 1);
  localparam logic [duty_bits-1:0] DUTY_MAX      = '1;
  localparam logic [duty_bits-1:0] DUTY_NEAR_MAX = DUTY_MAX - 1'b1;
  localparam logic [duty_bits-1:0] DUTY_ONE      = duty_bits'(1);

  typedef enum logic [1:0] {
    RISE   = 2'd0,
    TOP    = 2'd1,
    FALL   = 2'd2,
    BOTTOM = 2'd3
  } state_t;

  state_t               state;
  logic [PRESC_W-1:0]   presc_cnt;
  logic [duty_bits-1:0] pwm_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [duty_bits-1:0] duty_eff;
  logic                 pwm_ce;
  logic                 period_end;

  // en gates the slot strobe, so nothing downstream of it can advance
  // while frozen.
  assign pwm_ce     = en && (presc_cnt == PRESC_LAST);
  assign period_end = pwm_ce && (pwm_cnt == DUTY_MAX);

`ifdef GAMMA_EN
  logic [2*duty_bits-1:0] duty_wide;
  logic [2*duty_bits-1:0] duty_sq;
  logic                   gamma_unused;

  // Full 2N-bit square, then keep the upper half: (duty*duty) >> N.
  assign duty_wide    = {{duty_bits{1'b0}}, duty};
  assign duty_sq      = duty_wide * duty_wide;
  assign duty_eff     = duty_sq[2*duty_bits-1 -: duty_bits];
  assign gamma_unused = ^duty_sq[duty_bits-1:0];
`else
  assign duty_eff = duty;
`endif

  // Prescaler, slot counter and the PWM output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      led0        <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      if (en) begin
        if (presc_cnt == PRESC_LAST) begin
          presc_cnt <= '0;
        end else begin
          presc_cnt <= presc_cnt + 1'b1;
        end
      end
      if (pwm_ce) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      // Registered from the pre-edge pwm_cnt, so the pulse lands in the
      // cycle where pwm_cnt reads 0.
      period_tick <= period_end;
      led0        <= en && (pwm_cnt < duty_eff);
    end
  end

  // Breath FSM. Everything here moves only at a period boundary so the
  // duty never changes part-way through a PWM period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RISE;
      duty     <= '0;
      hold_cnt <= '0;
      dir      <= 1'b1;
    end else if (period_end) begin
      case (state)
        RISE: begin
          // The guard keeps duty from wrapping even if state and duty
          // were ever to disagree.
          if (duty != DUTY_MAX) begin
            duty <= duty + 1'b1;
          end
          if (duty == DUTY_NEAR_MAX || duty == DUTY_MAX) begin
            state    <= TOP;
            hold_cnt <= '0;
            dir      <= 1'b0;
          end
        end
        TOP: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= FALL;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        FALL: begin
          if (duty != '0) begin
            duty <= duty - 1'b1;
          end
          if (duty == DUTY_ONE || duty == '0) begin
            state    <= BOTTOM;
            hold_cnt <= '0;
          end
        end
        BOTTOM: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= RISE;
            dir   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RISE;
          duty     <= '0;
          hold_cnt <= '0;
          dir      <= 1'b1;
        end
      endcase
    end
  end

endmodule
